// File: rtl/arbiter_packet_rr.sv
// arbiter_packet_rr: packet-atomic round-robin merge of INPUT_NUMBER AXI-Stream
// inputs onto one output channel. A grant is taken on a routing-header beat
// while IDLE and held until the TLAST handshake, so packets never interleave.
// While LOCKED the granted input is passed straight through combinationally.
// Optional build macro: ARB_PKT_CNT_EN adds saturating per-input packet
// counters on pkt_count_o.

package axis_router_pkg;
  localparam int AXIS_DATA_WIDTH = 32;
  localparam int ID_WIDTH        = 4;
  localparam int DEST_WIDTH      = 4;
  localparam int USER_WIDTH      = 4;

  // TID value marking the first (routing header) beat of a packet
  localparam logic [ID_WIDTH-1:0] ROUTING_HEADER = 4'hF;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] TDATA;
    logic [ID_WIDTH-1:0]        TID;
    logic [DEST_WIDTH-1:0]      TDEST;
    logic [USER_WIDTH-1:0]      TUSER;
  } axis_data_t;

  typedef struct packed {
    logic       TVALID;
    logic       TLAST;
    axis_data_t data;
  } axis_mosi_t;

  typedef struct packed {
    logic TREADY;
  } axis_miso_t;
endpackage

`ifdef ARB_PKT_CNT_EN
// Per-input saturating packet counter
module arb_pkt_cnt (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);
  logic [15:0] cnt_q;

  // count completed packets, sticking at all-ones
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                         cnt_q <= '0;
    else if (inc_i && cnt_q != 16'hFFFF)  cnt_q <= cnt_q + 16'd1;
  end

  assign cnt_o = cnt_q;
endmodule
`endif

module arbiter_packet_rr
  import axis_router_pkg::*;
#(
  parameter int INPUT_NUMBER       = 5,
  parameter int INPUT_NUMBER_WIDTH = $clog2(INPUT_NUMBER)
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  axis_mosi_t [INPUT_NUMBER-1:0]       in_mosi_i,
  output axis_miso_t [INPUT_NUMBER-1:0]       in_miso_o,
  output axis_mosi_t                          out_mosi_o,
  input  axis_miso_t                          out_miso_i,
  output logic                                locked_o,
  output logic [INPUT_NUMBER_WIDTH-1:0]       current_grant_o
`ifdef ARB_PKT_CNT_EN
  ,output logic [INPUT_NUMBER-1:0][15:0]      pkt_count_o
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                          state;
  logic [INPUT_NUMBER_WIDTH-1:0]   grant_q;
  logic [INPUT_NUMBER_WIDTH-1:0]   ptr_q;
  logic [INPUT_NUMBER-1:0]         req;
  logic [INPUT_NUMBER_WIDTH-1:0]   winner;
  logic                            last_xfer;

  // only a valid routing-header beat may ask for the channel
  always_comb begin
    req = '0;
    for (int i = 0; i < INPUT_NUMBER; i++)
      req[i] = in_mosi_i[i].TVALID && (in_mosi_i[i].data.TID == ROUTING_HEADER);
  end

  // round-robin search from ptr_q; descending scan so the nearest offset wins
  always_comb begin
    winner = '0;
    for (int k = INPUT_NUMBER-1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % INPUT_NUMBER])
        winner = INPUT_NUMBER_WIDTH'((int'(ptr_q) + k) % INPUT_NUMBER);
    end
  end

  // pass-through of the granted input; everything quiet while IDLE
  always_comb begin
    out_mosi_o = '0;
    in_miso_o  = '0;
    if (state == LOCKED) begin
      out_mosi_o         = in_mosi_i[grant_q];
      in_miso_o[grant_q] = out_miso_i;
    end
  end

  assign last_xfer = (state == LOCKED) && out_mosi_o.TVALID &&
                     out_mosi_o.TLAST && out_miso_i.TREADY;

  // grant on a header, release on the TLAST handshake, advance pointer past owner
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          grant_q <= winner;
          state   <= LOCKED;
        end
        LOCKED: if (last_xfer) begin
          state <= IDLE;
          ptr_q <= (grant_q == INPUT_NUMBER_WIDTH'(INPUT_NUMBER-1)) ?
                   '0 : grant_q + INPUT_NUMBER_WIDTH'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign locked_o        = (state == LOCKED);
  assign current_grant_o = grant_q;

`ifdef ARB_PKT_CNT_EN
  for (genvar i = 0; i < INPUT_NUMBER; i++) begin : g_cnt
    arb_pkt_cnt u_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .inc_i   (last_xfer && (grant_q == INPUT_NUMBER_WIDTH'(i))),
      .cnt_o   (pkt_count_o[i])
    );
  end
`endif

endmodule

// File: tb/tb_arbiter_packet_rr.sv
// Bench for arbiter_packet_rr: per-input source queues feed the DUT, expected
// output beats go into a scoreboard queue, and a negedge monitor pops and
// compares every output handshake.
module tb_arbiter_packet_rr;
  import axis_router_pkg::*;

  localparam int N = 5;
  localparam int W = $clog2(N);

  logic clk_i = 1'b0;
  logic rst_n_i;
  always #5 clk_i = ~clk_i;

  axis_mosi_t [N-1:0] in_mosi;
  axis_miso_t [N-1:0] in_miso;
  axis_mosi_t         out_mosi;
  axis_miso_t         out_miso;
  logic               locked;
  logic [W-1:0]       grant;
`ifdef ARB_PKT_CNT_EN
  logic [N-1:0][15:0] pkt_count;
`endif

  arbiter_packet_rr #(.INPUT_NUMBER(N)) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .in_mosi_i       (in_mosi),
    .in_miso_o       (in_miso),
    .out_mosi_o      (out_mosi),
    .out_miso_i      (out_miso),
    .locked_o        (locked),
    .current_grant_o (grant)
`ifdef ARB_PKT_CNT_EN
    ,.pkt_count_o    (pkt_count)
`endif
  );

  typedef struct { logic [31:0] d; logic [3:0] id; logic last; } beat_t;
  typedef struct { axis_mosi_t m; int g; } exp_t;

  beat_t      src_q[N][$];
  exp_t       exp_q[$];
  int         xcyc[$];
  logic       rdy_q[$];
  logic [N-1:0] fire;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  function automatic axis_mosi_t mk(input beat_t b);
    axis_mosi_t m;
    m = '0;
    m.TVALID     = 1'b1;
    m.TLAST      = b.last;
    m.data.TDATA = b.d;
    m.data.TID   = b.id;
    m.data.TDEST = b.d[3:0];
    m.data.TUSER = ~b.d[3:0];
    return m;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // queue one packet on input i; body beats carry a non-header TID
  task automatic push_pkt(input int i, input int n, input logic [31:0] tag, input bit expect_it);
    for (int b = 0; b < n; b++) begin
      beat_t x;
      exp_t  e;
      x.d    = tag + 32'(b);
      x.id   = (b == 0) ? ROUTING_HEADER : 4'h3;
      x.last = (b == n-1);
      src_q[i].push_back(x);
      if (expect_it) begin
        e.m = mk(x);
        e.g = i;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || locked) && n < max_cyc) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= max_cyc) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d beats outstanding, locked=%0b", exp_q.size(), locked);
      exp_q.delete();
    end
    @(negedge clk_i);
  endtask

  // source driver: retire handshaken beats, present the next head of each queue
  initial begin
    in_mosi  = '0;
    out_miso = '0;
    forever begin
      @(posedge clk_i);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        in_mosi[i] = (src_q[i].size() > 0) ? mk(src_q[i][0]) : '0;
      end
      out_miso.TREADY = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
    end
  end

  // monitor: scoreboard on output handshakes, TREADY routing while locked
  always @(negedge clk_i) begin
    exp_t e;
    for (int i = 0; i < N; i++) fire[i] <= in_mosi[i].TVALID && in_miso[i].TREADY;
    if (rst_n_i && out_mosi.TVALID && out_miso.TREADY) begin
      xcyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %0h expected none", out_mosi);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", 64'(out_mosi), 64'(e.m));
        check("beat_grant", 64'(grant), 64'(e.g));
      end
    end
    if (locked)
      for (int i = 0; i < N; i++)
        check("tready_route", 64'(in_miso[i].TREADY),
              (i == int'(grant)) ? 64'(out_miso.TREADY) : 64'd0);
  end

  initial begin
    int c0;
    int offs[6];
    offs = '{0, 1, 3, 4, 6, 7};
    rst_n_i = 1'b0;

    // reset state
    repeat (2) @(posedge clk_i);
    #2;
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_out", 64'(out_mosi), 64'd0);
    check("rst_tready", 64'(in_miso), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // simultaneous headers on 0,1,4 with ptr=0 -> order 0,1,4, one IDLE between
    xcyc.delete();
    c0 = cyc;
    push_pkt(0, 2, 32'h100, 1'b1);
    push_pkt(1, 2, 32'h200, 1'b1);
    push_pkt(4, 2, 32'h400, 1'b1);
    wait_done(60);
    check("rr_nbeats", 64'(xcyc.size()), 64'd6);
    if (xcyc.size() == 6) begin
      check("rr_latency", 64'(xcyc[0]), 64'(c0 + 2));
      for (int k = 1; k < 6; k++)
        check("rr_spacing", 64'(xcyc[k] - xcyc[0]), 64'(offs[k]));
    end

    // single 4-beat packet on input 2, TREADY high
    xcyc.delete();
    c0 = cyc;
    push_pkt(2, 4, 32'h2000, 1'b1);
    @(negedge clk_i);
    check("p2_idle_first", 64'(locked), 64'd0);
    @(negedge clk_i);
    check("p2_locked", 64'(locked), 64'd1);
    check("p2_grant", 64'(grant), 64'd2);
    repeat (3) @(negedge clk_i);
    check("p2_locked_at_last", 64'(locked), 64'd1);
    @(negedge clk_i);
    check("p2_unlock", 64'(locked), 64'd0);
    check("p2_nbeats", 64'(xcyc.size()), 64'd4);
    if (xcyc.size() == 4) check("p2_consecutive", 64'(xcyc[3] - xcyc[0]), 64'd3);

    // ptr is now 3: headers on 2 and 3 -> 3 first, then 2
    push_pkt(3, 1, 32'h3100, 1'b1);
    push_pkt(2, 1, 32'h2100, 1'b1);
    wait_done(30);

    // back-pressure mid-packet with a competing header waiting on input 1
    c0 = cyc;
    push_pkt(0, 5, 32'h5000, 1'b1);
    push_pkt(1, 2, 32'h1500, 1'b1);
    rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    repeat (4) @(negedge clk_i);
    check("bp_stall_tready", 64'(in_miso[0].TREADY), 64'd0);
    check("bp_stall_valid", 64'(out_mosi.TVALID), 64'd1);
    check("bp_loser_tready", 64'(in_miso[1].TREADY), 64'd0);
    check("bp_grant", 64'(grant), 64'd0);
    wait_done(60);

    // non-header valid beat on input 3 while IDLE -> ignored
    begin
      beat_t x;
      x.d = 32'h3333; x.id = 4'h1; x.last = 1'b1;
      src_q[3].push_back(x);
    end
    repeat (3) begin
      @(negedge clk_i);
      check("nh_locked", 64'(locked), 64'd0);
      check("nh_tready", 64'(in_miso[3].TREADY), 64'd0);
      check("nh_out", 64'(out_mosi), 64'd0);
    end
    src_q[3].delete();
    repeat (2) @(negedge clk_i);

    // reset asserted on the second beat of a locked packet
    push_pkt(2, 4, 32'h7000, 1'b1);
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #3;
    check("mid_beat2_valid", 64'(out_mosi.TVALID), 64'd1);
    rst_n_i = 1'b0;
    #1;
    check("mid_rst_out", 64'(out_mosi), 64'd0);
    check("mid_rst_tready", 64'(in_miso), 64'd0);
    check("mid_rst_locked", 64'(locked), 64'd0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    check("post_rst_locked", 64'(locked), 64'd0);
    check("post_rst_grant", 64'(grant), 64'd0);
    // ptr must be 0 again: headers on 1 and 4 -> 1 first
    push_pkt(1, 1, 32'h8100, 1'b1);
    push_pkt(4, 1, 32'h8400, 1'b1);
    wait_done(30);

`ifdef ARB_PKT_CNT_EN
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int p = 0; p < 3; p++) push_pkt(1, 2, 32'h9000 + 32'(p * 16), 1'b1);
    wait_done(60);
    for (int i = 0; i < N; i++)
      check("cnt_three", 64'(pkt_count[i]), (i == 1) ? 64'd3 : 64'd0);
    force dut.g_cnt[1].u_cnt.cnt_q = 16'hFFFE;
    #1;
    release dut.g_cnt[1].u_cnt.cnt_q;
    @(negedge clk_i);
    for (int p = 0; p < 2; p++) push_pkt(1, 2, 32'hA000 + 32'(p * 16), 1'b1);
    wait_done(60);
    check("cnt_saturate", 64'(pkt_count[1]), 64'hFFFF);
    check("cnt_other", 64'(pkt_count[0]), 64'd0);
`endif

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/arbiter_packet_rr.md
Name: arbiter_packet_rr

Overview:
- Output-side counterpart of the per-input routing demux in the router.
- Collects AXI-Stream packets from INPUT_NUMBER input ports competing for one output channel and merges them onto that channel.
- Packet-atomic round-robin: a grant is taken on a routing-header beat and held until the TLAST handshake, so packets never interleave.
- One instance per router output channel.

Parameters:
- AXIS_DATA_WIDTH, 32, TDATA width carried in axis_mosi_t.
- INPUT_NUMBER, 5, number of competing input ports (must be >= 2).
- INPUT_NUMBER_WIDTH, $clog2(INPUT_NUMBER), width of grant index and pointer.
- ID_WIDTH / DEST_WIDTH / USER_WIDTH, 4, present under TID_PRESENT / TDEST_PRESENT / TUSER_PRESENT as in the other router blocks.

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  reset, asynchronous, active-low.
- in_mosi_i  input  axis_mosi_t [INPUT_NUMBER]  per-input stream from the routing demuxes.
- in_miso_o  output  axis_miso_t [INPUT_NUMBER]  per-input TREADY back-pressure.
- out_mosi_o  output  axis_mosi_t  merged stream to the output channel.
- out_miso_i  input  axis_miso_t  output channel back-pressure.
- locked_o  output  1  arbiter currently owns a packet.
- current_grant_o  output  INPUT_NUMBER_WIDTH  index of the granted input; meaningful only when locked_o=1.

Behaviour:
- State machine IDLE / LOCKED; registers state, grant_q, ptr_q.
- Reset (asynchronous, takes effect immediately, including mid-packet):
  - state=IDLE, grant_q=0, ptr_q=0.
  - out_mosi_o='0, every in_miso_o='0, locked_o=0, current_grant_o=0.
- Request definition: req[i] = in_mosi_i[i].TVALID && in_mosi_i[i].data.TID==ROUTING_HEADER. Non-header valid beats never request.
- IDLE:
  - out_mosi_o='0 and all TREADY=0; nothing is consumed.
  - If any req: winner = first i with req[i], searching ptr_q, ptr_q+1, ... with wrap modulo INPUT_NUMBER.
  - Next edge: grant_q<=winner, state<=LOCKED.
  - Arbitration latency is exactly 1 cycle from the header being valid to it being forwarded.
- LOCKED:
  - out_mosi_o = in_mosi_i[grant_q].
  - in_miso_o[grant_q] = out_miso_i; all other in_miso_o = '0.
  - Fully combinational pass-through: no added latency, no buffering.
  - Beat transfer = out_mosi_o.TVALID && out_miso_i.TREADY.
  - On a transfer with TLAST=1 (a header beat with TLAST=1 also qualifies): state<=IDLE, ptr_q<=(grant_q==INPUT_NUMBER-1) ? 0 : grant_q+1.
  - Otherwise stay LOCKED. TVALID low or TREADY low while LOCKED holds state indefinitely; no timeout.
- Simultaneous requests: only the round-robin winner is granted; losers keep TVALID with TREADY=0 (AXI-S rules: they must not drop or change data).
- The TLAST cycle always returns to IDLE. A new packet, including one from the same input, needs one IDLE cycle. Max throughput is therefore packet_len/(packet_len+1).
- Fairness: with all inputs continuously requesting, grant order is 0,1,2,...,INPUT_NUMBER-1,0,...
- locked_o = (state==LOCKED); current_grant_o = grant_q.

Optional Feature:
- Macro: ARB_PKT_CNT_EN.
- Defined:
  - Adds output pkt_count_o [INPUT_NUMBER] of 16-bit counters.
  - pkt_count_o[grant_q] increments on each TLAST transfer while LOCKED.
  - Counters saturate at 16'hFFFF and reset to 0 asynchronously.
  - Values are visible the cycle after the TLAST transfer. Intended for PMU readout.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Single packet, input 2 (header + 3 beats, last with TLAST), TREADY=1 throughout → IDLE 1 cycle, then 4 output beats on consecutive cycles, current_grant_o=2, locked_o drops the cycle after TLAST, ptr_q=3.
- Inputs 0, 1 and 4 all present headers in the same cycle with ptr_q=0, each packet 2 beats → output packet order 0, 1, 4; each granted packet separated by exactly 1 IDLE cycle; losers hold TVALID with TREADY=0.
- Back-pressure: out TREADY toggles 1,0,0,1 mid-packet → in_miso_o[grant] mirrors the toggles, no beat duplicated or lost; a competing header on another input is not granted until the TLAST transfer.
- Non-header beat (TID≠ROUTING_HEADER) valid on input 3 while IDLE → no grant, TREADY[3]=0, out_mosi_o stays 0.
- rst_n_i asserted on the 2nd beat of a LOCKED packet → out_mosi_o=0 and all TREADY=0 immediately; after release, state=IDLE and ptr_q=0.
- ARB_PKT_CNT_EN: 3 packets from input 1 → pkt_count_o[1]=3, others 0. With the counter preloaded near 16'hFFFF, 2 further packets → holds at 16'hFFFF.
